// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - state encoding and sizing helpers for raster_stream_tx
package raster_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } raster_state_e;

  function automatic int frame_period(input int width_line, input int height,
                                      input int h_blank, input int v_blank);
    return (width_line + h_blank) * (height + v_blank);
  endfunction

  // hcnt is shared by the active, hblank and vblank phases, so it is sized for the longest one
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - saturating terminal-count counter with clear, enable and done
module raster_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  assign done = (count == last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         count <= '0;
    else if (clr)         count <= '0;
    else if (en && !done) count <= count + 1'b1;
  end

endmodule

// File: rtl/raster_stream_tx.sv
// rtl/raster_stream_tx.sv - timed de/hs/vs raster transmitter fed by a valid/ready pixel source
// Build option RASTER_TEST_PATTERN_EN: underflow slots carry a hcnt pattern instead of zero.
module raster_stream_tx
  import raster_pkg::*;
#(
  parameter int IMG_WIDTH_DATA = 24,
  parameter int IMG_WIDTH_LINE = 800,
  parameter int IMG_HEIGHT     = 600,
  parameter int H_BLANK        = 160,
  parameter int V_BLANK        = 45
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_start,
  input  logic                      s_valid,
  input  logic [IMG_WIDTH_DATA-1:0] s_data,
  output logic                      s_ready,
  output logic                      o_de,
  output logic [IMG_WIDTH_DATA-1:0] o_data,
  output logic                      o_hs,
  output logic                      o_vs,
  output logic                      o_frame_done,
  output logic                      o_underflow
);

  localparam int V_SPAN = V_BLANK * (IMG_WIDTH_LINE + H_BLANK);
  localparam int HW     = cnt_width(IMG_WIDTH_LINE, H_BLANK, V_SPAN);
  localparam int VW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACTIVE = ACTIVE;
  localparam logic [1:0] S_HBLANK = HBLANK;
  localparam logic [1:0] S_VBLANK = VBLANK;

  logic [1:0]                state, state_nx;
  logic [HW-1:0]             hcnt, h_last;
  logic [VW-1:0]             vcnt;
  logic                      h_done, v_done;
  logic [IMG_WIDTH_DATA-1:0] fill;

  always_comb begin
    h_last = '0;
    case (state)
      S_ACTIVE: h_last = HW'(IMG_WIDTH_LINE - 1);
      S_HBLANK: h_last = HW'(H_BLANK - 1);
      S_VBLANK: h_last = HW'(V_SPAN - 1);
      default:  h_last = '0;
    endcase
  end

  // hcnt restarts on every phase change; vcnt restarts when the frame enters vblank
  raster_counter #(.WIDTH(HW)) u_hcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     ((state == S_IDLE) || h_done),
    .en      (1'b1),
    .last    (h_last),
    .count   (hcnt),
    .done    (h_done)
  );

  raster_counter #(.WIDTH(VW)) u_vcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     ((state == S_IDLE) || ((state == S_HBLANK) && h_done && v_done)),
    .en      ((state == S_HBLANK) && h_done),
    .last    (VW'(IMG_HEIGHT - 1)),
    .count   (vcnt),
    .done    (v_done)
  );

`ifdef RASTER_TEST_PATTERN_EN
  logic [7:0] pat;
  assign pat = 8'(hcnt);
  always_comb begin
    fill = '0;
    for (int i = 0; i < IMG_WIDTH_DATA; i++) fill[i] = pat[3'(i)];
  end
`else
  assign fill = '0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (i_start) state_nx = S_ACTIVE;
      S_ACTIVE: if (h_done) state_nx = S_HBLANK;
      S_HBLANK: if (h_done) state_nx = (vcnt < VW'(IMG_HEIGHT - 1)) ? S_ACTIVE : S_VBLANK;
      S_VBLANK: if (h_done) state_nx = i_start ? S_ACTIVE : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign s_ready = (state == S_ACTIVE);

  // every active cycle is a pixel slot; a missing pixel is filled rather than stretching the line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      o_de         <= 1'b0;
      o_data       <= '0;
      o_hs         <= 1'b0;
      o_vs         <= 1'b0;
      o_frame_done <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      state        <= state_nx;
      o_de         <= s_ready;
      o_data       <= s_ready ? (s_valid ? s_data : fill) : '0;
      o_hs         <= (state == S_HBLANK) && (hcnt == '0);
      o_vs         <= (state == S_VBLANK);
      o_frame_done <= (state == S_VBLANK) && h_done;
      if (s_ready && !s_valid) o_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_raster_stream_tx.sv
// tb/tb_raster_stream_tx.sv - self-checking bench for raster_stream_tx (8x4 active, 3/2 blanking)
module tb_raster_stream_tx;
  import raster_pkg::*;

  localparam int DW = 24;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int HB = 3;
  localparam int VB = 2;
  localparam int LT = W + HB;
  localparam int FP = frame_period(W, H, HB, VB);
`ifdef RASTER_TEST_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_start = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, o_de, o_hs, o_vs, o_frame_done, o_underflow;
  logic [DW-1:0] o_data;

  always #5 clk = ~clk;

  raster_stream_tx #(
    .IMG_WIDTH_DATA (DW),
    .IMG_WIDTH_LINE (W),
    .IMG_HEIGHT     (H),
    .H_BLANK        (HB),
    .V_BLANK        (VB)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .o_de         (o_de),
    .o_data       (o_data),
    .o_hs         (o_hs),
    .o_vs         (o_vs),
    .o_frame_done (o_frame_done),
    .o_underflow  (o_underflow)
  );

  typedef struct {
    int stop_frame;
    int stop_line;
    int uf_line;
    int uf_pix;
    bit all_inv;
    int exp_de;
    int exp_fd;
    bit exp_uf;
  } scen_t;

  scen_t tbl[5];

  int n_cmp = 0, n_bad = 0;
  bit m_run;
  int m_pos, m_frame;
  bit e_de, e_hs, e_vs, e_fd, e_uf;
  logic [DW-1:0] exp_q[$];
  int cyc = 0, de_run, fd_run, fd_cyc;

  int stop_frame = -1, stop_line = -1, uf_line = -1, uf_pix = -1;
  bit all_inv = 1'b0;
  int cur_de, cur_fd;
  bit cur_uf, timed_out, req_end = 1'b0;

  function automatic bit in_slot(input int p);
    return (p / LT < H) && (p % LT < W);
  endfunction

  function automatic logic [DW-1:0] fill(input int col);
    logic [7:0] b;
    b = 8'(col);
    return PAT_EN ? {3{b}} : '0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference timeline by frame position; pushes expected pixels and checks outputs mid-cycle
  always @(posedge clk or negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run <= 1'b0; m_pos <= 0; m_frame <= 0;
      e_de <= 1'b0; e_hs <= 1'b0; e_vs <= 1'b0; e_fd <= 1'b0; e_uf <= 1'b0;
      de_run <= 0; fd_run <= 0;
      exp_q.delete();
      if (!clk) begin
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_o_de", 32'(o_de), 0);
        chk("rst_o_data", 32'(o_data), 0);
        chk("rst_o_hs", 32'(o_hs), 0);
        chk("rst_o_vs", 32'(o_vs), 0);
        chk("rst_o_frame_done", 32'(o_frame_done), 0);
        chk("rst_o_underflow", 32'(o_underflow), 0);
      end
    end else if (clk) begin
      if (!m_run) begin
        e_de <= 1'b0; e_hs <= 1'b0; e_vs <= 1'b0; e_fd <= 1'b0;
        if (i_start) begin m_run <= 1'b1; m_pos <= 0; end
      end else begin
        e_de <= in_slot(m_pos);
        e_hs <= (m_pos / LT < H) && (m_pos % LT == W);
        e_vs <= (m_pos / LT >= H);
        e_fd <= (m_pos == FP - 1);
        if (in_slot(m_pos)) begin
          exp_q.push_back(s_valid ? s_data : fill(m_pos % LT));
          if (!s_valid) e_uf <= 1'b1;
        end
        if (m_pos == FP - 1) begin
          m_pos <= 0;
          m_frame <= m_frame + 1;
          if (!i_start) m_run <= 1'b0;
        end else begin
          m_pos <= m_pos + 1;
        end
      end
    end else begin
      cyc <= cyc + 1;
      chk("s_ready", 32'(s_ready), 32'(m_run && in_slot(m_pos)));
      chk("o_de", 32'(o_de), 32'(e_de));
      chk("o_hs", 32'(o_hs), 32'(e_hs));
      chk("o_vs", 32'(o_vs), 32'(e_vs));
      chk("o_frame_done", 32'(o_frame_done), 32'(e_fd));
      chk("o_underflow", 32'(o_underflow), 32'(e_uf));
      if (e_de && exp_q.size() > 0) chk("o_data", 32'(o_data), 32'(exp_q.pop_front()));
      else if (!e_de) chk("o_data_blank", 32'(o_data), 0);
      if (o_de) de_run <= de_run + 1;
      if (o_frame_done) begin
        if (fd_run > 0) chk("fd_spacing", cyc - fd_cyc, FP);
        fd_run <= fd_run + 1;
        fd_cyc <= cyc;
      end
      if (req_end) begin
        chk("timeout", 32'(timed_out), 0);
        chk("de_count", de_run, cur_de);
        chk("fd_count", fd_run, cur_fd);
        chk("uf_final", 32'(o_underflow), 32'(cur_uf));
        chk("sb_empty", exp_q.size(), 0);
      end
    end
  end

  task automatic run_cycle();
    int ln, cl;
    @(negedge clk);
    ln = m_pos / LT;
    cl = m_pos % LT;
    if (m_run && m_frame == stop_frame && ln == stop_line) i_start = 1'b0;
    s_valid = !(all_inv || (ln == uf_line && cl == uf_pix));
    s_data  = DW'(m_frame * 32 + ln * W + cl);
  endtask

  task automatic run_to_idle(input int budget);
    bit started;
    int n;
    started = 1'b0;
    n = 0;
    while (1) begin
      run_cycle();
      n++;
      if (m_run) started = 1'b1;
      if (started && !m_run) break;
      if (n >= budget) begin timed_out = 1'b1; break; end
    end
    repeat (20) run_cycle();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    i_start = 1'b0;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic end_check();
    @(posedge clk);
    req_end = 1'b1;
    @(posedge clk);
    req_end = 1'b0;
  endtask

  initial begin
    int n;
    //          stop_f stop_l uf_l uf_p inv  de  fd  uf
    tbl[0] = '{1,     0,     -1,  -1,  1'b0, 64, 2, 1'b0};
    tbl[1] = '{0,     2,      2,   5,  1'b0, 32, 1, 1'b1};
    tbl[2] = '{0,     1,     -1,  -1,  1'b0, 32, 1, 1'b0};
    tbl[3] = '{2,     1,     -1,  -1,  1'b0, 96, 3, 1'b0};
    tbl[4] = '{0,     1,     -1,  -1,  1'b1, 32, 1, 1'b1};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int s = 0; s < 5; s++) begin
      apply_reset();
      stop_frame = tbl[s].stop_frame;
      stop_line  = tbl[s].stop_line;
      uf_line    = tbl[s].uf_line;
      uf_pix     = tbl[s].uf_pix;
      all_inv    = tbl[s].all_inv;
      cur_de     = tbl[s].exp_de;
      cur_fd     = tbl[s].exp_fd;
      cur_uf     = tbl[s].exp_uf;
      timed_out  = 1'b0;
      i_start    = 1'b1;
      run_to_idle(400);
      end_check();
    end

    // reset while pixel 3 of line 1 is on the wire, then restart from line 0
    apply_reset();
    stop_frame = -1; stop_line = -1; uf_line = -1; uf_pix = -1; all_inv = 1'b0;
    timed_out = 1'b0;
    i_start = 1'b1;
    n = 0;
    while (!(m_run && m_pos == LT + 3) && n < 200) begin
      run_cycle();
      n++;
    end
    if (n >= 200) timed_out = 1'b1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    repeat (3) run_cycle();
    reset_n = 1'b1;
    stop_frame = 0; stop_line = 1;
    cur_de = 32; cur_fd = 1; cur_uf = 1'b0;
    run_to_idle(400);
    end_check();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
